deinterleaver_8bit: RTL and testbench

- Receive side of the block interleaver path. Accepts the serial, column-ordered bit stream produced by the interleaver and rebuilds the original 8-bit words.
- Stores one ROWS x 8 bit matrix, then drains it one word per handshake.
- Sits between the channel bit sink and the byte-oriented consumer.

---
 rtl/deinterleaver_8bit_pkg.sv | 9 +
 rtl/deinterleaver_8bit_if.sv | 24 ++
 rtl/deinterleaver_8bit_row_reg_bitwr.sv | 36 +++
 rtl/deinterleaver_8bit.sv | 100 ++++++++++
 tb/tb_deinterleaver_8bit.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/deinterleaver_8bit_pkg.sv
// Shared constants for the block deinterleaver.
// The state encoding is kept as plain constants so older tools can read it.
package deint_pkg;
    localparam int WORD_W       = 8;
    localparam int DEFAULT_ROWS = 8;

    localparam logic [0:0] FILL  = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;
endpackage

// File: rtl/deinterleaver_8bit_if.sv
// Bit-in / word-out handshake bundle for the deinterleaver.
// The master modport is the channel side, the slave modport is the block.
interface deint_if;
    import deint_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              bit_in;
    logic              in_first;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] data_out;
    logic              out_last;

    modport master (
        output in_valid, bit_in, in_first, out_ready,
        input  in_ready, out_valid, data_out, out_last
    );

    modport slave (
        input  in_valid, bit_in, in_first, out_ready,
        output in_ready, out_valid, data_out, out_last
    );
endinterface

// File: rtl/deinterleaver_8bit_row_reg_bitwr.sv
// One matrix row: 8 mux flops, each loading the broadcast bit when its enable is set.
// muxdff is the library cell the row is built from.
module muxdff (
    input  logic clk,
    input  logic reset,
    input  logic d0_i,
    input  logic d1_i,
    input  logic sel_i,
    output logic q_o
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_o <= 1'b0;
        else       q_o <= sel_i ? d1_i : d0_i;
    end
endmodule

module row_reg_bitwr
    import deint_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] we_i,
    input  logic              din_i,
    output logic [WORD_W-1:0] q_o
);
    for (genvar b = 0; b < WORD_W; b++) begin : g_bit
        muxdff u_ff (
            .clk   (clk),
            .reset (reset),
            .d0_i  (q_o[b]),
            .d1_i  (din_i),
            .sel_i (we_i[b]),
            .q_o   (q_o[b])
        );
    end
endmodule

// File: rtl/deinterleaver_8bit.sv
// Rebuilds 8-bit words from a column-ordered interleaved bit stream.
// Single buffer: fill ROWS x 8 bits, then drain one word per handshake.
module deinterleaver_8bit
    import deint_pkg::*;
#(
    parameter int ROWS = DEFAULT_ROWS
) (
    input  logic    clk,
    input  logic    reset,
    deint_if.slave  bus
);
    localparam int WIDTH = WORD_W;
    localparam int CW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] LAST = CW'(ROWS - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] rd_q, rd_d;
    logic [2:0]    col_q, col_d;

    logic          in_xfer;
    logic          out_xfer;
    logic [CW-1:0] wr_row;
    logic [2:0]    wr_col;

    logic [ROWS-1:0][WIDTH-1:0] mat;
    logic [ROWS-1:0][WIDTH-1:0] we;

    assign bus.in_ready  = (state_q == FILL);
    assign bus.out_valid = (state_q == DRAIN);
    assign bus.data_out  = bus.out_valid ? mat[rd_q] : '0;
    assign bus.out_last  = bus.out_valid && (rd_q == LAST);

    assign in_xfer  = bus.in_valid && bus.in_ready;
    assign out_xfer = bus.out_valid && bus.out_ready;

    // A resync bit always lands at position k = 0.
    assign wr_row = bus.in_first ? '0 : row_q;
    assign wr_col = bus.in_first ? '0 : col_q;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        assign we[r] = (in_xfer && wr_row == CW'(r))
                     ? (WIDTH'(1) << wr_col) : '0;

        row_reg_bitwr u_row (
            .clk   (clk),
            .reset (reset),
            .we_i  (we[r]),
            .din_i (bus.bit_in),
            .q_o   (mat[r])
        );
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        rd_d    = rd_q;

        if (in_xfer) begin
            if (bus.in_first) begin
                row_d = CW'(1);
                col_d = '0;
            end else if (row_q == LAST) begin
                row_d = '0;
                if (col_q == 3'd7) begin
                    col_d   = '0;
                    state_d = DRAIN;
                end else begin
                    col_d = col_q + 3'd1;
                end
            end else begin
                row_d = row_q + CW'(1);
            end
        end

        if (out_xfer) begin
            if (rd_q == LAST) begin
                rd_d    = '0;
                state_d = FILL;
            end else begin
                rd_d = rd_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
            row_q   <= '0;
            col_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            rd_q    <= rd_d;
        end
    end
endmodule

// File: tb/tb_deinterleaver_8bit.sv
// Directed bench for deinterleaver_8bit with ROWS = 8.
// Bits are interleaved from word lists; output words are checked against those lists.
module tb_deinterleaver_8bit;
    import deint_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    deint_if bus ();

    deinterleaver_8bit #(.ROWS(8)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int ir_low;

    logic [7:0] got_w[$];
    logic       got_l[$];

    logic [7:0] blk1[8] = '{8'h01, 8'h02, 8'h03, 8'h04,
                            8'h05, 8'h06, 8'h07, 8'h08};
    logic [7:0] bp[8]   = '{8'hA5, 8'h3C, 8'hFF, 8'h00,
                            8'h5A, 8'hC3, 8'h81, 8'h7E};
    logic [7:0] rs[8]   = '{8'h11, 8'h22, 8'h33, 8'h44,
                            8'h55, 8'h66, 8'h77, 8'h88};
    logic [7:0] blkf[8] = '{8'hF0, 8'hF1, 8'hF2, 8'hF3,
                            8'hF4, 8'hF5, 8'hF6, 8'hF7};

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called and returns at posedge+1; retries until the bit is accepted.
    task automatic send_bit(input logic b, input logic first, input bit bub);
        int   guard = 0;
        logic acc   = 1'b0;
        while (!acc && guard < 200) begin
            bus.in_valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.bit_in   = b;
            bus.in_first = first;
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!acc) chk("in_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_block(input logic [7:0] w[8],
                              input logic first, input bit bub);
        logic [7:0] wv;
        for (int k = 0; k < 64; k++) begin
            wv = w[k % 8];
            send_bit(wv[k / 8], first && (k == 0), bub);
        end
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        @(negedge clk);
        chk("first_lat", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic recv(input int n, input int stall_idx,
                        input int stall_cyc, input logic [7:0] stall_exp);
        int idx    = 0;
        int stalls = 0;
        int guard  = 0;
        got_w.delete();
        got_l.delete();
        ir_low = 0;
        while (idx < n && guard < 2000) begin
            bus.out_ready = !(idx == stall_idx && stalls < stall_cyc);
            @(negedge clk);
            guard++;
            if (!bus.in_ready) ir_low++;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                chk("stall_data", 32'(bus.data_out), 32'(stall_exp));
            end
            if (bus.out_valid && bus.out_ready) begin
                got_w.push_back(bus.data_out);
                got_l.push_back(bus.out_last);
                idx++;
            end
            @(posedge clk);
            #1;
        end
        if (idx < n) chk("out_timeout", 32'(idx), 32'(n));
    endtask

    task automatic check_words(input string name,
                               input logic [7:0] e[16], input int n);
        chk({name, "_count"}, 32'(got_w.size()), 32'(n));
        for (int i = 0; i < n && i < got_w.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), 32'(got_w[i]), 32'(e[i]));
            chk($sformatf("%s_l%0d", name, i), 32'(got_l[i]),
                32'((i % 8) == 7));
        end
    endtask

    function automatic void pad(input logic [7:0] a[8],
                                input logic [7:0] b[8],
                                output logic [7:0] e[16]);
        for (int i = 0; i < 8; i++) begin
            e[i]     = a[i];
            e[i + 8] = b[i];
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] e[16];

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.bit_in    = 1'b0;
        bus.in_first  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_data_out",  32'(bus.data_out),  32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // basic block
        fork
            send_block(blk1, 1'b0, 1'b0);
            recv(8, -1, 0, 8'h00);
        join
        pad(blk1, blk1, e);
        check_words("basic", e, 8);
        chk("basic_inready_low", 32'(ir_low), 32'd8);

        // backpressure, with bits offered during drain
        fork
            begin
                send_block(bp, 1'b0, 1'b0);
                repeat (10) begin
                    bus.in_valid = 1'b1;
                    bus.in_first = 1'b1;
                    bus.bit_in   = 1'b1;
                    @(negedge clk);
                    chk("drain_in_ready", 32'(bus.in_ready), 32'd0);
                    @(posedge clk);
                    #1;
                end
                bus.in_valid = 1'b0;
                bus.in_first = 1'b0;
            end
            recv(8, 2, 5, 8'hFF);
        join
        pad(bp, bp, e);
        check_words("bp", e, 8);

        // input bubbles, no resync marker
        fork
            send_block(bp, 1'b0, 1'b1);
            recv(8, -1, 0, 8'h00);
        join
        check_words("bubble", e, 8);

        // resync after garbage
        fork
            begin
                repeat (20) send_bit(1'($urandom_range(0, 1)), 1'b0, 1'b0);
                send_block(rs, 1'b1, 1'b0);
            end
            recv(8, -1, 0, 8'h00);
        join
        pad(rs, rs, e);
        check_words("resync", e, 8);

        // reset in the middle of drain
        fork
            send_block(blk1, 1'b0, 1'b0);
            recv(3, -1, 0, 8'h00);
        join
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("midrst_out_last",  32'(bus.out_last),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst           = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_idle_valid", 32'(bus.out_valid), 32'd0);
        fork
            send_block(blk1, 1'b0, 1'b0);
            recv(8, -1, 0, 8'h00);
        join
        pad(blk1, blk1, e);
        check_words("after_rst", e, 8);

        // two blocks back to back
        fork
            begin
                send_block(blk1, 1'b0, 1'b0);
                send_block(blkf, 1'b0, 1'b0);
            end
            recv(16, -1, 0, 8'h00);
        join
        pad(blk1, blkf, e);
        check_words("b2b", e, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
